// File: rtl/loader_pkg.sv
// ---------------------------------------------------------------------------
// loader_pkg : shared state encodings and protocol constants for the loader
// rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package loader_pkg;

  typedef enum logic [3:0] {
    ST_IDLE   = 4'd0,
    ST_LEN_LO = 4'd1,
    ST_LEN_HI = 4'd2,
    ST_DATA   = 4'd3,
    ST_CRC    = 4'd4,
    ST_RESP   = 4'd5
  } state_e;

  localparam logic [7:0] RESP_ACK = 8'h06;
  localparam logic [7:0] RESP_NAK = 8'h15;
  localparam logic [7:0] CRC_POLY = 8'h07;
  localparam logic [7:0] CRC_INIT = 8'h00;

endpackage

`default_nettype wire

// File: rtl/crc8_byte.sv
// ---------------------------------------------------------------------------
// crc8_byte : one-byte CRC-8 update, MSB-first, no reflection
// rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module crc8_byte
  import loader_pkg::*;
(
  input  logic [7:0] crc_i,
  input  logic [7:0] data_i,
  output logic [7:0] crc_o
);

  logic [7:0] c;

  always_comb begin
    c = crc_i ^ data_i;
    for (int i = 0; i < 8; i++) begin
      c = c[7] ? ((c << 1) ^ CRC_POLY) : (c << 1);
    end
    crc_o = c;
  end

endmodule

`default_nettype wire

// File: rtl/uart_imem_loader.sv
// ---------------------------------------------------------------------------
// uart_imem_loader : receives a framed program image over UART, writes it to
//                    instruction memory and holds the core in reset meanwhile
// rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module uart_imem_loader
  import loader_pkg::*;
#(
  parameter int         ADDR_W      = 14,
  parameter int         TIMEOUT_CYC = 2700000,
  parameter logic [7:0] SYNC_BYTE   = 8'hA5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              imem_we,
  output logic [ADDR_W-1:0] a_uart,
  output logic [31:0]       wd_uart,
  output logic              cpu_reset,
  output logic [7:0]        tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic [3:0]        state_tr,
  output logic              load_done
);

  state_e              state_q, state_d;
  logic [15:0]         len_q, len_d;
  logic [1:0]          bcnt_q, bcnt_d;
  logic [23:0]         buf_q, buf_d;
  logic [31:0]         wd_q, wd_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                we_q, we_d;
  logic                cpu_rst_q, cpu_rst_d;
  logic [7:0]          tx_data_q, tx_data_d;
  logic                tx_valid_q, tx_valid_d;
  logic                done_q, done_d;
  logic [7:0]          crc_q, crc_d;
  logic [31:0]         tout_q, tout_d;
  logic [7:0]          crc_upd;
  logic [15:0]         len_full;
  logic                in_frame;
  logic                expired;

  crc8_byte u_crc (
    .crc_i  (crc_q),
    .data_i (rx_data),
    .crc_o  (crc_upd)
  );

  assign in_frame = (state_q == ST_LEN_LO) || (state_q == ST_LEN_HI) ||
                    (state_q == ST_DATA)   || (state_q == ST_CRC);
  assign expired  = in_frame && !rx_valid && (tout_q == 32'(TIMEOUT_CYC - 1));
  assign len_full = {rx_data, len_q[7:0]};

  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    bcnt_d     = bcnt_q;
    buf_d      = buf_q;
    wd_d       = wd_q;
    addr_d     = addr_q;
    we_d       = 1'b0;
    cpu_rst_d  = cpu_rst_q;
    tx_data_d  = tx_data_q;
    tx_valid_d = tx_valid_q;
    done_d     = 1'b0;
    crc_d      = crc_q;
    tout_d     = '0;

    if (in_frame && !rx_valid) tout_d = tout_q + 32'd1;

    // Address advances the cycle after a write, except after the final word.
    if (we_q && state_q == ST_DATA) addr_d = addr_q + 1'b1;

    if (expired) begin
      state_d    = ST_RESP;
      tx_valid_d = 1'b1;
      tx_data_d  = RESP_NAK;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (rx_valid && rx_data == SYNC_BYTE) begin
            state_d   = ST_LEN_LO;
            cpu_rst_d = 1'b1;
            crc_d     = CRC_INIT;
            bcnt_d    = '0;
            addr_d    = '0;
          end
        end
        ST_LEN_LO: begin
          if (rx_valid) begin
            len_d   = {8'h00, rx_data};
            crc_d   = crc_upd;
            state_d = ST_LEN_HI;
          end
        end
        ST_LEN_HI: begin
          if (rx_valid) begin
            len_d = len_full;
            crc_d = crc_upd;
            if (len_full == 16'd0 || {16'd0, len_full} > (32'd1 << ADDR_W)) begin
              state_d    = ST_RESP;
              tx_valid_d = 1'b1;
              tx_data_d  = RESP_NAK;
            end else begin
              state_d = ST_DATA;
              addr_d  = '0;
              bcnt_d  = '0;
            end
          end
        end
        ST_DATA: begin
          if (rx_valid) begin
            crc_d  = crc_upd;
            bcnt_d = bcnt_q + 2'd1;
            case (bcnt_q)
              2'd0:    buf_d[7:0]   = rx_data;
              2'd1:    buf_d[15:8]  = rx_data;
              2'd2:    buf_d[23:16] = rx_data;
              default: begin
                wd_d = {rx_data, buf_q};
                we_d = 1'b1;
                if (32'(addr_q) + 32'd1 == {16'd0, len_q}) state_d = ST_CRC;
              end
            endcase
          end
        end
        ST_CRC: begin
          if (rx_valid) begin
            state_d    = ST_RESP;
            tx_valid_d = 1'b1;
            tx_data_d  = (rx_data == crc_q) ? RESP_ACK : RESP_NAK;
          end
        end
        ST_RESP: begin
          if (tx_ready) begin
            state_d    = ST_IDLE;
            tx_valid_d = 1'b0;
            if (tx_data_q == RESP_ACK) begin
              cpu_rst_d = 1'b0;
              done_d    = 1'b1;
            end
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      len_q      <= '0;
      bcnt_q     <= '0;
      buf_q      <= '0;
      wd_q       <= '0;
      addr_q     <= '0;
      we_q       <= 1'b0;
      cpu_rst_q  <= 1'b0;
      tx_data_q  <= '0;
      tx_valid_q <= 1'b0;
      done_q     <= 1'b0;
      crc_q      <= '0;
      tout_q     <= '0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      bcnt_q     <= bcnt_d;
      buf_q      <= buf_d;
      wd_q       <= wd_d;
      addr_q     <= addr_d;
      we_q       <= we_d;
      cpu_rst_q  <= cpu_rst_d;
      tx_data_q  <= tx_data_d;
      tx_valid_q <= tx_valid_d;
      done_q     <= done_d;
      crc_q      <= crc_d;
      tout_q     <= tout_d;
    end
  end

  assign imem_we   = we_q;
  assign a_uart    = addr_q;
  assign wd_uart   = wd_q;
  assign cpu_reset = cpu_rst_q;
  assign tx_data   = tx_data_q;
  assign tx_valid  = tx_valid_q;
  assign state_tr  = state_q;
  assign load_done = done_q;

endmodule

`default_nettype wire

// File: tb/tb_uart_imem_loader.sv
// ---------------------------------------------------------------------------
// tb_uart_imem_loader : scoreboard bench for the UART instruction-memory loader
// rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_uart_imem_loader;

  localparam int ADDR_W  = 14;
  localparam int TIMEOUT = 100;

  logic              clk = 1'b0;
  logic              reset;
  logic [7:0]        rx_data;
  logic              rx_valid;
  logic              imem_we;
  logic [ADDR_W-1:0] a_uart;
  logic [31:0]       wd_uart;
  logic              cpu_reset;
  logic [7:0]        tx_data;
  logic              tx_valid;
  logic              tx_ready;
  logic [3:0]        state_tr;
  logic              load_done;

  uart_imem_loader #(
    .ADDR_W      (ADDR_W),
    .TIMEOUT_CYC (TIMEOUT),
    .SYNC_BYTE   (8'hA5)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .imem_we   (imem_we),
    .a_uart    (a_uart),
    .wd_uart   (wd_uart),
    .cpu_reset (cpu_reset),
    .tx_data   (tx_data),
    .tx_valid  (tx_valid),
    .tx_ready  (tx_ready),
    .state_tr  (state_tr),
    .load_done (load_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [31:0]       data;
  } wr_t;

  wr_t        wq[$];
  logic [7:0] rq[$];
  int         vectors     = 0;
  int         miscompares = 0;
  int         done_pulses = 0;

  // Scoreboard monitor: pops expected writes and responses as the DUT emits them.
  always @(negedge clk) begin
    if (imem_we) begin
      vectors++;
      if (wq.size() == 0) begin
        miscompares++;
        $display("FAIL imem_write unexpected: a_uart=%h wd_uart=%h required=no write", a_uart, wd_uart);
      end else begin
        wr_t e;
        e = wq.pop_front();
        if (a_uart !== e.addr || wd_uart !== e.data) begin
          miscompares++;
          $display("FAIL imem_write: a_uart=%h wd_uart=%h required a_uart=%h wd_uart=%h",
                   a_uart, wd_uart, e.addr, e.data);
        end
      end
    end
    if (tx_valid && tx_ready) begin
      vectors++;
      if (rq.size() == 0) begin
        miscompares++;
        $display("FAIL tx_response unexpected: tx_data=%h required=no response", tx_data);
      end else begin
        logic [7:0] r;
        r = rq.pop_front();
        if (tx_data !== r) begin
          miscompares++;
          $display("FAIL tx_response: tx_data=%h required=%h", tx_data, r);
        end
      end
    end
    if (load_done) done_pulses++;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    repeat (2) @(posedge clk);
    #1 rx_data = b;
    rx_valid = 1'b1;
    @(posedge clk);
    #1 rx_valid = 1'b0;
  endtask

  task automatic frame1(input logic [7:0] crc);
    send_byte(8'hA5); send_byte(8'h01); send_byte(8'h00);
    send_byte(8'h78); send_byte(8'h56); send_byte(8'h34); send_byte(8'h12);
    send_byte(crc);
  endtask

  task automatic push_wr(input logic [ADDR_W-1:0] a, input logic [31:0] d);
    wr_t e;
    e.addr = a;
    e.data = d;
    wq.push_back(e);
  endtask

  task automatic wait_resp_done();
    int n = 0;
    while (!tx_valid && n < 500) begin @(posedge clk); #1; n++; end
    while (tx_valid && n < 500) begin @(posedge clk); #1; n++; end
    if (n >= 500) begin
      vectors++;
      miscompares++;
      $display("FAIL resp_wait: no completed response within 500 cycles, required handshake");
    end
    @(posedge clk); #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_state"},     32'(state_tr),  32'd0);
    check({tag, "_imem_we"},   32'(imem_we),   32'd0);
    check({tag, "_a_uart"},    32'(a_uart),    32'd0);
    check({tag, "_wd_uart"},   wd_uart,        32'd0);
    check({tag, "_cpu_reset"}, 32'(cpu_reset), 32'd0);
    check({tag, "_tx_valid"},  32'(tx_valid),  32'd0);
    check({tag, "_tx_data"},   32'(tx_data),   32'd0);
    check({tag, "_load_done"}, 32'(load_done), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int  cnt;
    bit  stable;
    reset    = 1'b0;
    rx_data  = 8'h00;
    rx_valid = 1'b0;
    tx_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 check_reset_outputs("reset");
    reset = 1'b1;

    // Good load: CRC of 01 00 78 56 34 12 is 0x21.
    push_wr('0, 32'h12345678);
    rq.push_back(8'h06);
    frame1(8'h21);
    check("load_cpu_reset_held", 32'(cpu_reset), 32'd1);
    wait_resp_done();
    check("load_cpu_reset_released", 32'(cpu_reset), 32'd0);
    check("load_state_idle", 32'(state_tr), 32'd0);
    check("load_done_count1", 32'(done_pulses), 32'd1);

    // Bad CRC: write still happens, NAK, core stays held.
    push_wr('0, 32'h12345678);
    rq.push_back(8'h15);
    frame1(8'h20);
    wait_resp_done();
    check("badcrc_cpu_reset", 32'(cpu_reset), 32'd1);
    check("badcrc_load_done", 32'(done_pulses), 32'd1);

    // Length zero and length one past the memory size.
    rq.push_back(8'h15);
    send_byte(8'hA5); send_byte(8'h00); send_byte(8'h00);
    wait_resp_done();
    rq.push_back(8'h15);
    send_byte(8'hA5); send_byte(8'h01); send_byte(8'h40);
    wait_resp_done();
    check("len_cpu_reset", 32'(cpu_reset), 32'd1);

    // Timeout after the first of two words.
    push_wr('0, 32'h44332211);
    rq.push_back(8'h15);
    send_byte(8'hA5); send_byte(8'h02); send_byte(8'h00);
    send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
    cnt = 0;
    while (!tx_valid && cnt < 300) begin @(posedge clk); #1; cnt++; end
    check("timeout_latency", 32'(cnt), 32'(TIMEOUT));
    wait_resp_done();

    // Backpressure on the response.
    tx_ready = 1'b0;
    push_wr('0, 32'h12345678);
    rq.push_back(8'h06);
    frame1(8'h21);
    stable = 1'b1;
    repeat (20) begin
      @(posedge clk); #1;
      if (!tx_valid || tx_data !== 8'h06 || state_tr !== 4'd5) stable = 1'b0;
    end
    check("bp_stable", 32'(stable), 32'd1);
    tx_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_state_idle", 32'(state_tr), 32'd0);
    check("bp_tx_valid_low", 32'(tx_valid), 32'd0);
    check("bp_cpu_reset", 32'(cpu_reset), 32'd0);
    repeat (2) @(posedge clk);
    #1 check("bp_load_done_count", 32'(done_pulses), 32'd2);

    // Reset mid-frame after two data bytes, then a clean reload.
    send_byte(8'hA5); send_byte(8'h01); send_byte(8'h00);
    send_byte(8'h78); send_byte(8'h56);
    #3 reset = 1'b0;
    #1 check_reset_outputs("midreset");
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    repeat (10) @(posedge clk);
    #1 check("midreset_no_resp", 32'(tx_valid), 32'd0);
    push_wr('0, 32'h12345678);
    rq.push_back(8'h06);
    frame1(8'h21);
    wait_resp_done();
    check("reload_cpu_reset", 32'(cpu_reset), 32'd0);
    check("reload_load_done_count", 32'(done_pulses), 32'd3);

    repeat (5) @(posedge clk);
    #1;
    check("writes_outstanding", 32'(wq.size()), 32'd0);
    check("responses_outstanding", 32'(rq.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
